timer_count_core: RTL
=====================

// Module: timer_count_core
// PURPOSE
//  Consumes the 100Hz square wave from the clock divider and runs the two-mode timer: stopwatch (count up) or countdown.
//  Keeps MM:SS.cc as BCD and drives the 7-segment display stage.
//  The whole block runs in the CLK_50MHz domain.
//  CLK_100Hz is treated as data: synchronised, then edge-detected into single-cycle ticks.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop stages synchronising CLK_100Hz (minimum 2)
// PORTS
//  CLK_50MHz    in   1  system clock; all state updates on its rising edge
//  rst          in   1  asynchronous, active-high reset
//  CLK_100Hz    in   1  100Hz square wave from divider; each rising edge = one 10ms tick
//  mode         in   1  0 = stopwatch (up), 1 = countdown (down); sampled only on clear
//  start_stop   in   1  single-cycle pulse; run/pause toggle
//  clear        in   1  single-cycle pulse; return to IDLE and reload
//  load_min     in   8  countdown preset minutes, BCD 00-99
//  load_sec     in   8  countdown preset seconds, BCD 00-59
//  cs_bcd       out  8  centiseconds, BCD 00-99
//  sec_bcd      out  8  seconds, BCD 00-59
//  min_bcd      out  8  minutes, BCD 00-99
//  running      out  1  high while state == RUN
//  done         out  1  high while state == DONE
// BEHAVIOUR
//  Reset (async, immediate):
//   - state = IDLE, mode_q = 0, all BCD outputs = 00, running = 0, done = 0, synchroniser cleared.
//  Tick generation:
//   - tick = rising edge of the last synchroniser stage; exactly one cycle wide.
//   - tick asserts SYNC_STAGES+1 clocks after CLK_100Hz rises.
//  FSM states: IDLE, RUN, PAUSE, DONE. clear has priority in every state.
//   - clear (any state) -> IDLE; mode_q <= mode.
//       - mode 0: count <= 00:00.00.
//       - mode 1: count <= load_min:load_sec.00.
//   - IDLE: start_stop -> RUN.
//       - Exception: mode_q = 1 and count = 00:00.00 -> DONE.
//       - Ticks are ignored in IDLE.
//   - RUN, on tick: count +1cs (mode_q = 0) or -1cs (mode_q = 1), BCD ripple.
//       - Up: cs 99->00 carries to sec; sec 59->00 carries to min.
//       - Down: cs 00->99 borrows; sec 00->59 borrows.
//   - RUN, start_stop -> PAUSE.
//       - If tick arrives the same cycle, the count is updated first, then PAUSE.
//   - RUN up-count end: tick at 99:59.99 -> count holds 99:59.99 (no wrap), state -> DONE.
//   - RUN down-count end: the tick that produces 00:00.00 also moves state -> DONE.
//       - done = 1 from the following cycle, with the display at 00:00.00.
//   - PAUSE: count frozen; ticks ignored; start_stop -> RUN.
//   - DONE: count frozen; ticks and start_stop ignored; only clear leaves.
//  Mode handling:
//   - mode changes outside a clear pulse have no effect.
//   - mode_q selects direction for the whole run.
//  Load sanitising, applied at clear in mode 1:
//   - Any BCD units nibble > 9 loads as 9.
//   - load_sec tens > 5 loads as 5.
//   - load_min tens > 9 loads as 9.
//  Outputs:
//   - Registered; they change the cycle after the causing tick or pulse.
//   - running/done are decoded from the state register; never both high.
// TESTING
//  1. Stopwatch count: rst, clear (mode 0), start_stop, 100 ticks -> 00:01.00; 6000 ticks from start -> 01:00.00, running = 1.
//  2. Countdown to end: mode 1, load 00:02, clear, start_stop, 200 ticks -> 00:00.00, done = 1 next cycle; 5 further ticks -> unchanged.
//  3. Pause and resume: stopwatch, 37 ticks, start_stop -> cs = 37 held over 50 ticks; start_stop, 3 ticks -> cs = 40.
//  4. Simultaneous events in RUN:
//     - clear + start_stop + tick in the same cycle -> IDLE, count reloaded, no increment.
//     - start_stop + tick -> count +1, then PAUSE.
//  5. Zero-preset countdown: mode 1, load 00:00, clear, start_stop -> DONE on the next cycle.
//     Also: load_sec = 8'h7A -> sanitised load of 59.
//  6. Reset mid-run: countdown at 01:23.45, assert rst between clock edges -> outputs 00 and done/running 0 immediately; after release, ticks ignored until start.

Source files
------------

// File: rtl/timer_count_core.sv
// timer_count_core: stopwatch / countdown timer keeping MM:SS.cc in BCD.
// CLK_100Hz is sampled as data in the CLK_50MHz domain and edge-detected
// into one-cycle ticks that drive a four-state run/pause FSM.
//
// Ports:
//   CLK_50MHz   in   system clock, all state on its rising edge
//   rst         in   asynchronous active-high reset
//   CLK_100Hz   in   100Hz square wave, each rising edge is one 10ms tick
//   mode        in   0 = count up, 1 = count down (taken only on clear)
//   start_stop  in   one-cycle run/pause toggle
//   clear       in   one-cycle return to IDLE with reload
//   load_min    in   countdown preset minutes, BCD
//   load_sec    in   countdown preset seconds, BCD
//   cs_bcd      out  centiseconds, BCD
//   sec_bcd     out  seconds, BCD
//   min_bcd     out  minutes, BCD
//   running     out  high in RUN
//   done        out  high in DONE
module timer_count_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_50MHz,
    input  logic       rst,
    input  logic       CLK_100Hz,
    input  logic       mode,
    input  logic       start_stop,
    input  logic       clear,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_tick;
    logic                   r_mode;

    logic [3:0] r_m1, r_m0, r_s1, r_s0, r_c1, r_c0;

    logic [4:0] w_c0s, w_c1s, w_s0s, w_s1s, w_m0s, w_m1s;
    logic [3:0] w_ld_m1, w_ld_m0, w_ld_s1, w_ld_s0;
    logic       w_is_zero;
    logic       w_end_up;
    logic       w_end_dn;
    logic       w_count_en;

    // One BCD digit step; bit 4 is the carry (up) or borrow (down) out.
    function automatic logic [4:0] f_step(
        input logic [3:0] d,
        input logic [3:0] lim,
        input logic       en,
        input logic       dn
    );
        logic [4:0] v;
        v = {1'b0, d};
        if (en) begin
            if (dn)
                v = (d == 4'd0) ? {1'b1, lim} : {1'b0, d - 4'd1};
            else
                v = (d == lim) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
        end
        return v;
    endfunction

    // Synchroniser and rising-edge detector; r_tick lands SYNC_STAGES+1
    // clocks after CLK_100Hz rises.
    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], CLK_100Hz};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_tick <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign w_c0s = f_step(r_c0, 4'd9, 1'b1,     r_mode);
    assign w_c1s = f_step(r_c1, 4'd9, w_c0s[4], r_mode);
    assign w_s0s = f_step(r_s0, 4'd9, w_c1s[4], r_mode);
    assign w_s1s = f_step(r_s1, 4'd5, w_s0s[4], r_mode);
    assign w_m0s = f_step(r_m0, 4'd9, w_s1s[4], r_mode);
    assign w_m1s = f_step(r_m1, 4'd9, w_m0s[4], r_mode);

    assign w_is_zero = ({r_m1, r_m0, r_s1, r_s0, r_c1, r_c0} == 24'd0);

    // Carry out of the top digit means the up-count sits at 99:59.99.
    assign w_end_up = ~r_mode & w_m1s[4];
    assign w_end_dn = r_mode &
        ({w_m1s[3:0], w_m0s[3:0], w_s1s[3:0],
          w_s0s[3:0], w_c1s[3:0], w_c0s[3:0]} == 24'd0);

    assign w_count_en = (r_state == RUN) & r_tick & ~w_end_up;

    // Out-of-range preset digits clamp to the largest legal digit.
    assign w_ld_m1 = (load_min[7:4] > 4'd9) ? 4'd9 : load_min[7:4];
    assign w_ld_m0 = (load_min[3:0] > 4'd9) ? 4'd9 : load_min[3:0];
    assign w_ld_s1 = (load_sec[7:4] > 4'd5) ? 4'd5 : load_sec[7:4];
    assign w_ld_s0 = (load_sec[3:0] > 4'd9) ? 4'd9 : load_sec[3:0];

    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_m1   <= 4'd0;
            r_m0   <= 4'd0;
            r_s1   <= 4'd0;
            r_s0   <= 4'd0;
            r_c1   <= 4'd0;
            r_c0   <= 4'd0;
        end else if (clear) begin
            r_mode <= mode;
            r_m1   <= mode ? w_ld_m1 : 4'd0;
            r_m0   <= mode ? w_ld_m0 : 4'd0;
            r_s1   <= mode ? w_ld_s1 : 4'd0;
            r_s0   <= mode ? w_ld_s0 : 4'd0;
            r_c1   <= 4'd0;
            r_c0   <= 4'd0;
        end else if (w_count_en) begin
            r_m1 <= w_m1s[3:0];
            r_m0 <= w_m0s[3:0];
            r_s1 <= w_s1s[3:0];
            r_s0 <= w_s0s[3:0];
            r_c1 <= w_c1s[3:0];
            r_c0 <= w_c0s[3:0];
        end
    end

    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_stop)
                        w_next_state = (r_mode & w_is_zero) ? DONE : RUN;
                end
                RUN: begin
                    if (r_tick & (w_end_up | w_end_dn))
                        w_next_state = DONE;
                    else if (start_stop)
                        w_next_state = PAUSE;
                end
                PAUSE: begin
                    if (start_stop)
                        w_next_state = RUN;
                end
                default: w_next_state = DONE;
            endcase
        end
    end

    always_comb begin
        running = (r_state == RUN);
        done    = (r_state == DONE);
    end

    assign cs_bcd  = {r_c1, r_c0};
    assign sec_bcd = {r_s1, r_s0};
    assign min_bcd = {r_m1, r_m0};

endmodule
